mem_request_queue: RTL and testbench
====================================

# mem_request_queue

Downstream memory stage that sits between the L1 arbiter and the memory bus. It buffers read and write requests from the arbiter in an in-order request queue, and applies them to a real cacheline backing store, so written data can be read back. Read responses return after a fixed pipeline delay, tagged with the issuing client id. It replaces the stateless magic memory, with which it keeps signal-level compatibility.

## Interface
- DEPTH, 4, request queue entries (power of two, ≥2)
- DELAY, 5, read pipeline stages from dequeue to response (≥2)
- INDEX_BITS, 6, backing store index width; 2^INDEX_BITS lines of 128 bits

- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- addr_in  in  32  byte address; line index = addr_in[INDEX_BITS+3:4], other bits ignored
- data_in  in  128  write cacheline
- rden  in  1  read request, single-cycle pulse per request
- wren  in  1  write request, single-cycle pulse per request
- client_id_in  in  1  requester (0 = A, 1 = B)
- en  in  1  downstream enable; 0 freezes dequeue and read pipeline
- data_out  out  128  read cacheline
- data_out_valid  out  1  one-cycle strobe per read response
- client_id_out  out  1  client id of the response on data_out
- queue_full  out  1  registered; count == DEPTH
- queue_count  out  $clog2(DEPTH)+1  registered occupancy
- overflow  out  1  sticky; a request was dropped because the queue was full

## Operation
- Entry = {type, index, data, client_id}. rden&wren together enqueue one write; the read is ignored.
- Enqueue: when (rden|wren) and the registered queue_full==0. This holds regardless of en.
- Enqueue attempted while queue_full==1: the request is dropped and overflow is set. overflow clears only on reset.
- Dequeue: at most one entry per edge, when en==1 and count>0, strictly in order.
- Dequeued write: store[index] <= data at that edge. No response.
- Dequeued read: store[index] is read and enters pipeline stage 1 with client_id.
  - A write dequeued at an earlier edge is visible to the read.
  - Write and read to the same index are never dequeued in the same edge.
- Pipeline: DELAY stages of {valid, client_id, data}. It advances only when en==1. When en==0, all stages, data_out, data_out_valid and client_id_out hold.
- Enqueue and dequeue on the same edge: count unchanged.
  - Full queue with a same-edge dequeue still rejects the enqueue, because full is evaluated on the registered count.
- Pointers wrap modulo DEPTH.
- Reset (mid-operation included):
  - Queue emptied.
  - Pipeline valids cleared; in-flight reads are lost.
  - Outputs: data_out=0, data_out_valid=0, client_id_out=0, queue_full=0, queue_count=0, overflow=0.
  - Store contents per Configuration.

## Timing
- Read sampled at edge N into an empty queue, en high throughout: dequeued at N+1; data_out_valid high for exactly the cycle after edge N+DELAY. Latency = DELAY cycles.
- Each queued request ahead of a read adds 1 cycle. Each en-low cycle adds 1 cycle.
- Back-to-back reads, one per cycle, give back-to-back valid strobes in request order.
- queue_full and queue_count update at the edge after the enqueue/dequeue.

## Configuration
- MEMQ_STORE_CLEAR_EN defined: reset zeroes every backing store line in the reset cycle.
- MEMQ_STORE_CLEAR_EN undefined: reset leaves store contents untouched. The store is X until written in simulation.

## Test plan
- Reset with MEMQ_STORE_CLEAR_EN, then a read of addr 0x40 from client 1 at edge N: data_out=0 and client_id_out=1, valid after edge N+5, one cycle wide.
- Write 0xDEADBEEF…(128'h…EF) to 0x1230, then a read of 0x1230 on the next cycle: the read returns the written value; no response is produced for the write.
- en=0 during cycles 2–4 of a read's flight: valid is delayed by exactly 3 cycles, and data/client are held stable.
- With en=0, issue 5 reads with DEPTH=4: queue_full=1 after the 4th; the 5th is dropped and overflow=1. Then en=1: exactly 4 responses, in order.
- rden&wren together to 0x80 with data 128'h1: a single write is performed, no response, queue_count=1 for one cycle.
- Reset asserted with 2 reads in flight and 2 queued: no data_out_valid after reset; all outputs 0; queue_count=0.

Source files
------------

// File: rtl/mem_request_queue.sv
// mem_request_queue
//   In-order request queue in front of a 128-bit cacheline backing store.
//   Writes update the store when dequeued. Reads sample the store when
//   dequeued and return through a DELAY-stage pipeline, tagged with client id.
//
// Ports
//   clk, reset        clock (rising edge), synchronous active-high reset
//   addr_in           byte address, line index = addr_in[INDEX_BITS+3:4]
//   data_in           write cacheline
//   rden, wren        single-cycle request pulses (both high -> one write)
//   client_id_in      requester id
//   en                downstream enable, 0 freezes dequeue and read pipeline
//   data_out          read cacheline
//   data_out_valid    one-cycle strobe per read response
//   client_id_out     client id of the response on data_out
//   queue_full        registered, occupancy == DEPTH
//   queue_count       registered occupancy
//   overflow          sticky, a request was dropped because the queue was full
//
// Build option
//   MEMQ_STORE_CLEAR_EN  when defined, reset zeroes every backing store line.
//                        When undefined, reset leaves the store untouched.
module mem_request_queue #(
  parameter int DEPTH      = 4,
  parameter int DELAY      = 5,
  parameter int INDEX_BITS = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              addr_in,
  input  logic [127:0]             data_in,
  input  logic                     rden,
  input  logic                     wren,
  input  logic                     client_id_in,
  input  logic                     en,
  output logic [127:0]             data_out,
  output logic                     data_out_valid,
  output logic                     client_id_out,
  output logic                     queue_full,
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LINES = 1 << INDEX_BITS;

  // Queue entries
  logic                  q_wr_q   [DEPTH];
  logic [INDEX_BITS-1:0] q_idx_q  [DEPTH];
  logic [127:0]          q_data_q [DEPTH];
  logic                  q_cid_q  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q;
  logic             overflow_q;

  logic [127:0] store_q [LINES];

  // Read pipeline, stage 0 is loaded at dequeue, last stage drives the outputs
  logic         pv_q [DELAY];
  logic         pc_q [DELAY];
  logic [127:0] pd_q [DELAY];

  logic                  req, enq, drop, deq, deq_wr, deq_rd;
  logic                  head_wr, head_cid;
  logic [INDEX_BITS-1:0] head_idx, in_idx;
  logic [127:0]          head_data, rd_data;

  logic unused_addr;
  assign unused_addr = ^{addr_in[31:INDEX_BITS+4], addr_in[3:0]};

  assign in_idx    = addr_in[INDEX_BITS+3:4];
  assign head_wr   = q_wr_q[rd_ptr_q];
  assign head_idx  = q_idx_q[rd_ptr_q];
  assign head_data = q_data_q[rd_ptr_q];
  assign head_cid  = q_cid_q[rd_ptr_q];
  assign rd_data   = store_q[head_idx];

  always_comb begin
    req    = rden | wren;
    // Full is taken from the registered flag, so a same-edge dequeue does not
    // make room for an incoming request.
    enq    = req & ~full_q;
    drop   = req & full_q;
    deq    = en & (count_q != '0);
    deq_wr = deq & head_wr;
    deq_rd = deq & ~head_wr;
    count_d = count_q;
    if (enq && !deq) begin
      count_d = count_q + CNT_W'(1);
    end else if (!enq && deq) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_wr_q[wr_ptr_q]   <= wren;
      q_idx_q[wr_ptr_q]  <= in_idx;
      q_data_q[wr_ptr_q] <= data_in;
      q_cid_q[wr_ptr_q]  <= client_id_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (enq) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (deq) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      if (drop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
`ifdef MEMQ_STORE_CLEAR_EN
    if (reset) begin
      for (int i = 0; i < LINES; i++) store_q[i] <= '0;
    end else
`endif
    if (deq_wr) begin
      store_q[head_idx] <= head_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DELAY; k++) begin
        pv_q[k] <= 1'b0;
        pc_q[k] <= 1'b0;
        pd_q[k] <= '0;
      end
    end else if (en) begin
      pv_q[0] <= deq_rd;
      pc_q[0] <= deq_rd ? head_cid : 1'b0;
      pd_q[0] <= deq_rd ? rd_data : '0;
      for (int k = 1; k < DELAY; k++) begin
        pv_q[k] <= pv_q[k-1];
        pc_q[k] <= pc_q[k-1];
        pd_q[k] <= pd_q[k-1];
      end
    end
  end

  assign data_out       = pd_q[DELAY-1];
  assign data_out_valid = pv_q[DELAY-1];
  assign client_id_out  = pc_q[DELAY-1];
  assign queue_full     = full_q;
  assign queue_count    = count_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_mem_request_queue.sv
module tb_mem_request_queue;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  addr_in;
  logic [127:0] data_in;
  logic         rden, wren, client_id_in, en;
  logic [127:0] data_out;
  logic         data_out_valid, client_id_out, queue_full, overflow;
  logic [2:0]   queue_count;

  int n_err = 0;
  int n_chk = 0;

  localparam logic [127:0] BEEF = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

  mem_request_queue #(.DEPTH(4), .DELAY(5), .INDEX_BITS(6)) dut (
    .clk            (clk),
    .reset          (reset),
    .addr_in        (addr_in),
    .data_in        (data_in),
    .rden           (rden),
    .wren           (wren),
    .client_id_in   (client_id_in),
    .en             (en),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .client_id_out  (client_id_out),
    .queue_full     (queue_full),
    .queue_count    (queue_count),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [127:0] d, input logic c);
    rden = rd; wren = wr; addr_in = a; data_in = d; client_id_in = c;
    step();
    rden = 1'b0; wren = 1'b0;
  endtask

  // Waits for the next response; latency counted in edges from the current sample point.
  task automatic wait_resp(input string tag, input int exp_lat,
                           input logic [127:0] exp_d, input logic exp_c);
    int lat = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (data_out_valid) begin
        lat = i;
        break;
      end
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_data"}, data_out, exp_d);
    check({tag, "_cid"}, client_id_out, exp_c);
  endtask

  task automatic count_valids(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (data_out_valid) n++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int nv;
    int got;
    reset = 1'b0; addr_in = '0; data_in = '0;
    rden = 1'b0; wren = 1'b0; client_id_in = 1'b0; en = 1'b1;
    step();
    do_reset();
    check("rst_count", queue_count, 0);
    check("rst_full", queue_full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_valid", data_out_valid, 0);
    check("rst_data", data_out, 0);
    check("rst_cid", client_id_out, 0);

    // Read of line 0x40 from client 1 after reset
`ifndef MEMQ_STORE_CLEAR_EN
    issue(1'b0, 1'b1, 32'h40, 128'h0, 1'b0);
    step();
`endif
    issue(1'b1, 1'b0, 32'h40, 128'h0, 1'b1);
    check("t1_count", queue_count, 1);
    wait_resp("t1", 5, 128'h0, 1'b1);
    step();
    check("t1_width", data_out_valid, 0);

    // Write then read-back on the next cycle
    issue(1'b0, 1'b1, 32'h1230, BEEF, 1'b0);
    issue(1'b1, 1'b0, 32'h1230, 128'h0, 1'b0);
    wait_resp("t2", 5, BEEF, 1'b0);
    step();
    check("t2_width", data_out_valid, 0);

    // en low for three edges during flight, then hold of a presented response
    issue(1'b1, 1'b0, 32'h1230, 128'h0, 1'b1);
    step();
    en = 1'b0;
    step(); step(); step();
    check("t3_frozen", data_out_valid, 0);
    en = 1'b1;
    wait_resp("t3", 4, BEEF, 1'b1);
    en = 1'b0;
    step(); step();
    check("t3_hold_v", data_out_valid, 1);
    check("t3_hold_d", data_out, BEEF);
    check("t3_hold_c", client_id_out, 1);
    en = 1'b1;
    step();
    check("t3_release", data_out_valid, 0);

    // Fill with en low, overflow on the 5th, same-edge drop when full
    for (int k = 0; k < 4; k++) issue(1'b0, 1'b1, 32'h100 + 32'(k * 16), 128'(32'hA0 + k), 1'b0);
    step(); step();
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      issue(1'b1, 1'b0, 32'h100 + 32'((k % 4) * 16), 128'h0, k[0]);
      if (k == 2) check("t4_full_early", queue_full, 0);
      if (k == 3) begin
        check("t4_full", queue_full, 1);
        check("t4_count4", queue_count, 4);
        check("t4_ovf_early", overflow, 0);
      end
    end
    check("t4_ovf", overflow, 1);
    check("t4_count_after", queue_count, 4);
    en = 1'b1;
    issue(1'b1, 1'b0, 32'h130, 128'h0, 1'b1);
    check("t4_sameedge_count", queue_count, 3);
    check("t4_sameedge_full", queue_full, 0);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (data_out_valid) begin
        if (got < 4) begin
          check("t4_order_data", data_out, 128'(32'hA0 + got));
          check("t4_order_cid", client_id_out, 128'(got % 2));
        end
        got++;
      end
    end
    check("t4_resp_count", got, 4);
    check("t4_ovf_sticky", overflow, 1);

    // rden and wren together: one write, no response
    issue(1'b1, 1'b1, 32'h80, 128'h1, 1'b1);
    check("t5_count1", queue_count, 1);
    step();
    check("t5_count0", queue_count, 0);
    count_valids(8, nv);
    check("t5_no_resp", nv, 0);
    issue(1'b1, 1'b0, 32'h80, 128'h0, 1'b0);
    wait_resp("t5_rb", 5, 128'h1, 1'b0);
    step();

    // Reset with two reads in flight and two queued
    issue(1'b1, 1'b0, 32'h100, 128'h0, 1'b0);
    issue(1'b1, 1'b0, 32'h110, 128'h0, 1'b1);
    issue(1'b1, 1'b0, 32'h120, 128'h0, 1'b0);
    en = 1'b0;
    issue(1'b1, 1'b0, 32'h130, 128'h0, 1'b1);
    check("t6_pre_count", queue_count, 2);
    en = 1'b1;
    do_reset();
    check("t6_count", queue_count, 0);
    check("t6_full", queue_full, 0);
    check("t6_ovf", overflow, 0);
    check("t6_valid", data_out_valid, 0);
    check("t6_data", data_out, 0);
    check("t6_cid", client_id_out, 0);
    count_valids(10, nv);
    check("t6_no_resp", nv, 0);
    check("t6_count_after", queue_count, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
